// File: rtl/sl_pkg.sv
// ---------------------------------------------------------------------------
// sl_pkg
// Shared definitions for the convolution result read-back slice.
//   rd_state_e  : reader FSM states (IDLE, RUN, FIN)
//   FIFO_DEPTH  : number of entries in the output skid FIFO
// ---------------------------------------------------------------------------
package sl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } rd_state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/sl_result_reader_if.sv
// ---------------------------------------------------------------------------
// sl_result_reader_if
// Valid/ready result stream from the reader to the host / next stage.
//   valid : data holds a result word
//   ready : sink accepts; a transfer is valid & ready
//   data  : result word, in address order
//   last  : marks the final word of a burst
// Modports: master (reader side), slave (sink side).
// ---------------------------------------------------------------------------
interface sl_result_reader_if #(
  parameter int DATA_W = 16
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/sl_skid_fifo.sv
// ---------------------------------------------------------------------------
// sl_skid_fifo
// Two-entry FIFO that absorbs memory read data so the reader can keep one
// word in flight while the sink stalls.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_data this cycle
//   i_data    : word to write
//   i_pop     : consume the head word this cycle
//   o_data    : head word (stable until popped)
//   o_valid   : FIFO not empty
//   o_count   : number of stored words (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module sl_skid_fifo
  import sl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_do_push = i_push && ((r_count != 2'(FIFO_DEPTH)) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/sl_result_reader.sv
// ---------------------------------------------------------------------------
// sl_result_reader
// Streams num_words results from the convolution output memory, starting at
// base_addr (wrapping), over a valid/ready interface once the convolution
// controller signals done.
//   clk, rst          : clock, asynchronous active-high reset
//   i_start           : one-cycle start pulse (controller done)
//   i_base_addr       : first read address, sampled on accepted start
//   i_num_words       : burst length, sampled on accepted start (0 allowed)
//   o_mem_rd_en       : read strobe to output memory
//   o_mem_addr        : read address
//   i_mem_rd_data     : read data, one cycle after o_mem_rd_en
//   out_if (master)   : result stream valid/ready/data/last
//   o_busy            : burst in progress (accepted start .. rd_done)
//   o_rd_done         : one-cycle pulse after the final transfer
//   o_start_dropped   : one-cycle pulse for a start that arrived while busy
//   o_checksum        : only with SL_READER_CHECKSUM_EN; modular sum of
//                       transferred words, cleared on accepted start
// Optional feature macro: SL_READER_CHECKSUM_EN
// ---------------------------------------------------------------------------
module sl_result_reader
  import sl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 9,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_num_words,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  sl_result_reader_if.master out_if,
  output logic              o_busy,
  output logic              o_rd_done,
  output logic              o_start_dropped
`ifdef SL_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] o_checksum
`endif
);

  if (MEM_LAT != 1) begin : g_lat_check
    $error("sl_result_reader supports only MEM_LAT == 1");
  end

  rd_state_e         r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_sent;
  logic              r_inflight;
  logic              r_busy;
  logic              r_rd_done;
  logic              r_start_dropped;

  logic              w_fifo_valid;
  logic [DATA_W-1:0] w_fifo_data;
  logic [1:0]        w_fifo_count;
  logic              w_pop;
  logic              w_is_last;
  logic [2:0]        w_occupancy;
  logic              w_issue;

  assign w_pop     = w_fifo_valid && out_if.ready;
  assign w_is_last = (r_sent == r_num - CNT_W'(1));

  // Words already committed to the FIFO after this cycle's pop; keeping this
  // below the depth means a read never returns into a full FIFO.
  assign w_occupancy = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue     = (r_state == RUN) && (r_issued < r_num) &&
                       (w_occupancy < 3'(FIFO_DEPTH));

  assign o_mem_rd_en = w_issue;
  assign o_mem_addr  = r_base + r_issued[ADDR_W-1:0];

  // Only data from a read issued since the last reset is captured, so a
  // read that returns after reset is dropped.
  sl_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (i_mem_rd_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign out_if.valid = w_fifo_valid;
  assign out_if.data  = w_fifo_data;
  assign out_if.last  = w_fifo_valid && w_is_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_base          <= '0;
      r_num           <= '0;
      r_issued        <= '0;
      r_sent          <= '0;
      r_inflight      <= 1'b0;
      r_busy          <= 1'b0;
      r_rd_done       <= 1'b0;
      r_start_dropped <= 1'b0;
    end else begin
      r_start_dropped <= 1'b0;
      r_inflight      <= w_issue;
      if (w_issue) r_issued <= r_issued + CNT_W'(1);
      if (w_pop)   r_sent   <= r_sent + CNT_W'(1);
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_base   <= i_base_addr;
            r_num    <= i_num_words;
            r_issued <= '0;
            r_sent   <= '0;
            r_busy   <= 1'b1;
            if (i_num_words == '0) begin
              r_state   <= FIN;
              r_rd_done <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (i_start) r_start_dropped <= 1'b1;
          if (w_pop && w_is_last) begin
            r_state   <= FIN;
            r_rd_done <= 1'b1;
          end
        end
        FIN: begin
          if (i_start) r_start_dropped <= 1'b1;
          r_state   <= IDLE;
          r_rd_done <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_rd_done <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_rd_done       = r_rd_done;
  assign o_start_dropped = r_start_dropped;

`ifdef SL_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if ((r_state == IDLE) && i_start) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + w_fifo_data;
    end
  end

  assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_sl_result_reader.sv
// ---------------------------------------------------------------------------
// tb_sl_result_reader
// Directed bench for sl_result_reader with a transaction-level model:
// expected words/addresses are queued when a start is accepted, each transfer
// must match the queue head, and issue/busy/rd_done/start_dropped follow from
// word counts. Scenario results are also pinned against hand-computed values.
// Honours SL_READER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_sl_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  baseAddr;
  logic [8:0]  numWords;
  logic        memRdEn;
  logic [7:0]  memAddr;
  logic [15:0] memRdData = 16'h0;
  logic        busy;
  logic        rdDone;
  logic        startDropped;
`ifdef SL_READER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  sl_result_reader_if #(.DATA_W(16)) outIf ();

  sl_result_reader #(
    .DATA_W(16), .ADDR_W(8), .CNT_W(9), .MEM_LAT(1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (start),
    .i_base_addr     (baseAddr),
    .i_num_words     (numWords),
    .o_mem_rd_en     (memRdEn),
    .o_mem_addr      (memAddr),
    .i_mem_rd_data   (memRdData),
    .out_if          (outIf.master),
    .o_busy          (busy),
    .o_rd_done       (rdDone),
    .o_start_dropped (startDropped)
`ifdef SL_READER_CHECKSUM_EN
    ,
    .o_checksum      (checksum)
`endif
  );

  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;
  int cycle      = 0;
  int readyMode  = 0;

  // Model state
  bit mBusy       = 1'b0;
  bit expDrop     = 1'b0;
  int expData[$];
  int expAddr[$];
  int mNum        = 0;
  int issuedCnt   = 0;
  int sentCnt     = 0;
  int outstanding = 0;
  int rdDoneCycle = -1;
  int startCycle  = -1;
  int sumModel    = 0;

  // Logs for scenario-level checks
  int xferLog[$];
  int xferCycle[$];
  int addrLog[$];
  int dropCount   = 0;
  int rdDoneSeen  = -1;

  function automatic int memValue(input int a);
    return (a * 3) & 16'hFFFF;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Memory with one cycle of read latency, contents mem[a] = a*3.
  always @(posedge clk) begin
    if (memRdEn) memRdData <= 16'(memValue(int'(memAddr)));
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Ready patterns: 0 = always ready, 1 = 1,0,0 repeating, 2 = never ready.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      1:       outIf.ready = ((cycle % 3) == 0);
      2:       outIf.ready = 1'b0;
      default: outIf.ready = 1'b1;
    endcase
  end

  // Compare process: checks DUT outputs against the model every cycle.
  always @(negedge clk) begin
    int pop;
    bit nextBusy;
    if (rst) begin
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_valid", outIf.valid, 0);
      checkOutput("reset_rd_en", memRdEn, 0);
      checkOutput("reset_rd_done", rdDone, 0);
      checkOutput("reset_dropped", startDropped, 0);
      mBusy = 0; expDrop = 0; expData.delete(); expAddr.delete();
      mNum = 0; issuedCnt = 0; sentCnt = 0; outstanding = 0; rdDoneCycle = -1;
    end else begin
      pop = (outIf.valid && outIf.ready) ? 1 : 0;
      checkOutput("busy", busy, mBusy);
      checkOutput("rd_done", rdDone, (cycle == rdDoneCycle));
      checkOutput("start_dropped", startDropped, expDrop);
      if (rdDone) rdDoneSeen = cycle;
      if (startDropped) dropCount++;
      expDrop = 0;

      if (memRdEn) begin
        addrLog.push_back(int'(memAddr));
        checkOutput("issue_allowed", (issuedCnt < mNum) && (outstanding - pop < 2), 1);
        if (expAddr.size() > 0) checkOutput("mem_addr", memAddr, expAddr.pop_front());
        issuedCnt++;
      end else if (mBusy && (issuedCnt < mNum) && (outstanding - pop < 2)) begin
        checkOutput("issue_missed", memRdEn, 1);
      end

      if (outIf.valid) begin
        if (expData.size() == 0) begin
          checkOutput("spurious_valid", outIf.valid, 0);
        end else begin
          checkOutput("out_data", outIf.data, expData[0]);
          checkOutput("out_last", outIf.last, (sentCnt == mNum - 1));
          if (outIf.ready) begin
            xferLog.push_back(int'(outIf.data));
            xferCycle.push_back(cycle);
            sumModel = (sumModel + int'(outIf.data)) & 16'hFFFF;
            void'(expData.pop_front());
            sentCnt++;
            if (sentCnt == mNum) rdDoneCycle = cycle + 1;
          end
        end
      end
      outstanding += (memRdEn ? 1 : 0) - pop;

      nextBusy = mBusy;
      if (cycle == rdDoneCycle) nextBusy = 0;
      if (start) begin
        if (mBusy) begin
          expDrop = 1;
        end else begin
          for (int i = 0; i < int'(numWords); i++) begin
            expAddr.push_back((int'(baseAddr) + i) % 256);
            expData.push_back(memValue((int'(baseAddr) + i) % 256));
          end
          mNum = int'(numWords); issuedCnt = 0; sentCnt = 0; sumModel = 0;
          startCycle = cycle;
          nextBusy = 1;
          if (numWords == 0) rdDoneCycle = cycle + 1;
        end
      end
      mBusy = nextBusy;
    end
  end

  task automatic applyStimulus(input logic [7:0] base, input logic [8:0] num);
    @(posedge clk);
    #1;
    start = 1'b1; baseAddr = base; numWords = num;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    int n = 0;
    @(posedge clk);
    while (mBusy && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput({name, "_completion"}, mBusy, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic clearLogs();
    xferLog.delete(); xferCycle.delete(); addrLog.delete();
    dropCount = 0; rdDoneSeen = -1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; baseAddr = 8'h0; numWords = 9'h0; outIf.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Scenario 1: base 0x10, 4 words, always ready
    $display("[TB] burst of 4 from 0x10");
    clearLogs(); readyMode = 0;
    applyStimulus(8'h10, 9'd4);
    waitIdle("s1", 50);
    checkOutput("s1_count", xferLog.size(), 4);
    if (xferLog.size() == 4) begin
      checkOutput("s1_w0", xferLog[0], 16'h30);
      checkOutput("s1_w1", xferLog[1], 16'h33);
      checkOutput("s1_w2", xferLog[2], 16'h36);
      checkOutput("s1_w3", xferLog[3], 16'h39);
      checkOutput("s1_back_to_back", xferCycle[3] - xferCycle[0], 3);
      checkOutput("s1_rd_done_after_last", rdDoneSeen - xferCycle[3], 1);
    end
`ifdef SL_READER_CHECKSUM_EN
    checkOutput("s1_checksum_model", checksum, sumModel);
    checkOutput("s1_checksum", checksum, 16'h00D2);
`endif

    // Scenario 2: 5 words with ready 1,0,0 pattern
    $display("[TB] burst of 5 with stalls");
    clearLogs(); readyMode = 1;
    applyStimulus(8'h30, 9'd5);
    waitIdle("s2", 100);
    checkOutput("s2_count", xferLog.size(), 5);
    if (xferLog.size() == 5) begin
      checkOutput("s2_first", xferLog[0], 16'h90);
      checkOutput("s2_last", xferLog[4], 16'h9C);
    end

    // Scenario 3: zero-length start
    $display("[TB] zero-length burst");
    clearLogs(); readyMode = 0;
    applyStimulus(8'h44, 9'd0);
    waitIdle("s3", 10);
    checkOutput("s3_no_reads", addrLog.size(), 0);
    checkOutput("s3_no_data", xferLog.size(), 0);
    checkOutput("s3_rd_done_soon", (rdDoneSeen - startCycle >= 1) && (rdDoneSeen - startCycle <= 2), 1);

    // Scenario 4: address wrap
    $display("[TB] address wrap from 0xFE");
    clearLogs();
    applyStimulus(8'hFE, 9'd4);
    waitIdle("s4", 50);
    checkOutput("s4_naddr", addrLog.size(), 4);
    if (addrLog.size() == 4) begin
      checkOutput("s4_a0", addrLog[0], 8'hFE);
      checkOutput("s4_a1", addrLog[1], 8'hFF);
      checkOutput("s4_a2", addrLog[2], 8'h00);
      checkOutput("s4_a3", addrLog[3], 8'h01);
    end
    if (xferLog.size() == 4) checkOutput("s4_w2", xferLog[2], 16'h0000);

    // Scenario 5: start during a 6-word burst is dropped
    $display("[TB] start while busy");
    clearLogs();
    applyStimulus(8'h50, 9'd6);
    n = 0;
    while (xferLog.size() < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 start = 1'b1; baseAddr = 8'h80; numWords = 9'd2;
    @(posedge clk);
    #1 start = 1'b0;
    waitIdle("s5", 50);
    checkOutput("s5_drop_count", dropCount, 1);
    checkOutput("s5_count", xferLog.size(), 6);
    if (xferLog.size() == 6) checkOutput("s5_last", xferLog[5], 16'h00FF);

    // Scenario 6: reset with buffered words, then a fresh burst
    $display("[TB] reset mid-burst");
    clearLogs(); readyMode = 2;
    applyStimulus(8'h40, 9'd8);
    n = 0;
    while (!(outstanding == 2 && outIf.valid) && n < 20) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    checkOutput("s6_busy_now", busy, 0);
    checkOutput("s6_valid_now", outIf.valid, 0);
    checkOutput("s6_rd_en_now", memRdEn, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; readyMode = 0;
    clearLogs();
    applyStimulus(8'h20, 9'd3);
    waitIdle("s6", 50);
    checkOutput("s6_count", xferLog.size(), 3);
    if (xferLog.size() == 3) begin
      checkOutput("s6_w0", xferLog[0], 16'h60);
      checkOutput("s6_w1", xferLog[1], 16'h63);
      checkOutput("s6_w2", xferLog[2], 16'h66);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
